// File: rtl/moving_average_pkg.sv
// Shared types and constants for the moving-average filter bank sequencer.
package moving_average_pkg;

  localparam int unsigned SEL_W = 2;

  localparam int unsigned Settle0Default = 2;
  localparam int unsigned Settle1Default = 4;
  localparam int unsigned Settle2Default = 8;
  localparam int unsigned Settle3Default = 9;

  typedef enum logic [1:0] {
    StFlush,
    StSettle,
    StRun
  } state_e;

  // Number of filter output strobes to discard after a flush for a given select.
  function automatic int unsigned settle_len(input logic [SEL_W-1:0] sel,
                                             input int unsigned s0, input int unsigned s1,
                                             input int unsigned s2, input int unsigned s3);
    int unsigned len;
    case (sel)
      2'd0:    len = s0;
      2'd1:    len = s1;
      2'd2:    len = s2;
      default: len = s3;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for quasi-static multi-bit pad inputs.
module sync_2ff #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '0;
      q_o    <= '0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/moving_average_sequencer.sv
// Filter-width switching control: flushes the bank on a select change and
// qualifies the bank output until the new window is fully populated.
module moving_average_sequencer #(
  parameter int unsigned SEL_W        = moving_average_pkg::SEL_W,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned SETTLE_0     = moving_average_pkg::Settle0Default,
  parameter int unsigned SETTLE_1     = moving_average_pkg::Settle1Default,
  parameter int unsigned SETTLE_2     = moving_average_pkg::Settle2Default,
  parameter int unsigned SETTLE_3     = moving_average_pkg::Settle3Default,
  parameter int unsigned CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena_i,
  input  logic [SEL_W-1:0] sel_req_i,
  input  logic             strobe_i,
  input  logic             filt_strobe_i,
  output logic [SEL_W-1:0] sel_o,
  output logic             flush_o,
  output logic             strobe_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             drop_o
);
  import moving_average_pkg::*;

  localparam int unsigned CntMax = (1 << CNT_W) - 1;
  localparam logic [CNT_W-1:0] FlushLast = CNT_W'(FLUSH_CYCLES - 1);

  if (SEL_W != 2) begin : gen_bad_sel_w
    $error("SEL_W must be 2: one settle length per select code");
  end
  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15 || FLUSH_CYCLES > CntMax) begin : gen_bad_flush
    $error("FLUSH_CYCLES out of range");
  end
  if (SETTLE_0 < 1 || SETTLE_0 > CntMax || SETTLE_1 < 1 || SETTLE_1 > CntMax ||
      SETTLE_2 < 1 || SETTLE_2 > CntMax || SETTLE_3 < 1 || SETTLE_3 > CntMax) begin : gen_bad_settle
    $error("SETTLE_x out of range for CNT_W");
  end

  logic [SEL_W-1:0] sel_s;
  logic [SEL_W-1:0] sel_prev_q;
  state_e           state_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] settle_cnt_q;
  logic [CNT_W-1:0] flush_inc;
  logic [CNT_W-1:0] settle_inc;
  logic [CNT_W-1:0] settle_tgt;
  logic             pass;
  logic             sel_change;

  sync_2ff #(
    .Width (SEL_W)
  ) u_sel_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (sel_req_i),
    .q_o   (sel_s)
  );

  always_comb begin
    pass       = ena_i && (state_q != StFlush);
    sel_change = (sel_s != sel_o);
    // Counters saturate rather than wrap.
    flush_inc  = (flush_cnt_q == '1) ? flush_cnt_q : flush_cnt_q + CNT_W'(1);
    settle_inc = (settle_cnt_q == '1) ? settle_cnt_q : settle_cnt_q + CNT_W'(1);
    settle_tgt = CNT_W'(settle_len(sel_o, SETTLE_0, SETTLE_1, SETTLE_2, SETTLE_3));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StFlush;
      flush_cnt_q  <= '0;
      settle_cnt_q <= '0;
      sel_prev_q   <= '0;
      sel_o        <= '0;
      flush_o      <= 1'b0;
      strobe_o     <= 1'b0;
      valid_o      <= 1'b0;
      busy_o       <= 1'b0;
      drop_o       <= 1'b0;
    end else begin
      strobe_o <= strobe_i & pass;
      drop_o   <= strobe_i & ~pass;
      if (ena_i) begin
        // Status outputs follow the state one cycle later, so valid_o falls
        // on the same edge that raises flush_o.
        flush_o    <= (state_q == StFlush);
        busy_o     <= (state_q != StRun);
        valid_o    <= (state_q == StRun);
        sel_prev_q <= sel_s;
        unique case (state_q)
          StFlush: begin
            if (sel_s != sel_prev_q) begin
              flush_cnt_q <= '0;
            end else if (flush_cnt_q >= FlushLast) begin
              sel_o        <= sel_s;
              settle_cnt_q <= '0;
              state_q      <= StSettle;
            end else begin
              flush_cnt_q <= flush_inc;
            end
          end
          StSettle: begin
            // A select change beats a final settling strobe in the same cycle.
            if (sel_change) begin
              flush_cnt_q <= '0;
              state_q     <= StFlush;
            end else if (filt_strobe_i) begin
              settle_cnt_q <= settle_inc;
              if (settle_inc == settle_tgt) begin
                state_q <= StRun;
              end
            end
          end
          StRun: begin
            if (sel_change) begin
              flush_cnt_q <= '0;
              state_q     <= StFlush;
            end
          end
          default: begin
            flush_cnt_q <= '0;
            state_q     <= StFlush;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_moving_average_sequencer.sv
// Scoreboard bench: stimulus queues expected events, a negedge monitor checks them.
module tb_moving_average_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena_i;
  logic [1:0] sel_req_i;
  logic       strobe_i;
  logic       filt_strobe_i;
  logic [1:0] sel_o;
  logic       flush_o;
  logic       strobe_o;
  logic       valid_o;
  logic       busy_o;
  logic       drop_o;

  moving_average_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena_i         (ena_i),
    .sel_req_i     (sel_req_i),
    .strobe_i      (strobe_i),
    .filt_strobe_i (filt_strobe_i),
    .sel_o         (sel_o),
    .flush_o       (flush_o),
    .strobe_o      (strobe_o),
    .valid_o       (valid_o),
    .busy_o        (busy_o),
    .drop_o        (drop_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  int         q_flush[$];
  int         q_strobe[$];
  int         q_drop[$];
  logic [1:0] q_valid[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  logic valid_prev = 1'b0;
  int   flen = 0;
  always @(negedge clk) begin : monitor
    int exp_i;
    logic [1:0] exp_s;
    if (valid_o === 1'b1 && !valid_prev) begin
      if (q_valid.size() == 0) check("unexpected valid_o rise", 1, 0);
      else begin
        exp_s = q_valid.pop_front();
        check("sel_o at valid rise", int'(sel_o), int'(exp_s));
        check("busy_o at valid rise", int'(busy_o), 0);
      end
    end
    valid_prev = (valid_o === 1'b1);
    if (flush_o === 1'b1) begin
      if (flen == 0) check("valid_o low at flush rise", int'(valid_o), 0);
      flen++;
    end else if (flen > 0) begin
      if (q_flush.size() == 0) check("unexpected flush pulse", 1, 0);
      else begin
        exp_i = q_flush.pop_front();
        check("flush_o width", flen, exp_i);
      end
      flen = 0;
    end
    if (strobe_o === 1'b1) begin
      if (q_strobe.size() == 0) check("unexpected strobe_o", 1, 0);
      else begin
        exp_i = q_strobe.pop_front();
        check("strobe_o cycle", cyc, exp_i);
      end
    end
    if (drop_o === 1'b1) begin
      if (q_drop.size() == 0) check("unexpected drop_o", 1, 0);
      else begin
        exp_i = q_drop.pop_front();
        check("drop_o cycle", cyc, exp_i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_filt(input int n);
    for (int i = 0; i < n; i++) begin
      filt_strobe_i = 1'b1;
      tick();
      filt_strobe_i = 1'b0;
      tick();
    end
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 40 && valid_o !== 1'b1; i++) tick();
    check(name, int'(valid_o === 1'b1), 1);
    ticks(2);
  endtask

  task automatic check_zero(input string name);
    @(negedge clk);
    check(name, int'({sel_o, flush_o, strobe_o, valid_o, busy_o, drop_o}), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; ena_i = 1'b1; sel_req_i = 2'd0; strobe_i = 1'b0; filt_strobe_i = 1'b0;
    ticks(3);
    check_zero("reset outputs");
    tick();

    // Reset release with a strobe during FLUSH, then settle select 0.
    rst_n = 1'b1;
    strobe_i = 1'b1;
    q_drop.push_back(cyc + 1);
    q_flush.push_back(2);
    q_valid.push_back(2'd0);
    tick();
    strobe_i = 1'b0;
    ticks(4);
    pulse_filt(2);
    wait_valid("valid after sel0 settle");

    // RUN strobe path, then ena_i low.
    strobe_i = 1'b1;
    q_strobe.push_back(cyc + 1);
    tick();
    strobe_i = 1'b0;
    tick();
    ena_i = 1'b0;
    strobe_i = 1'b1;
    filt_strobe_i = 1'b1;
    q_drop.push_back(cyc + 1);
    tick();
    strobe_i = 1'b0;
    filt_strobe_i = 1'b0;
    tick();
    check("valid_o held with ena low", int'(valid_o), 1);
    check("flush_o held with ena low", int'(flush_o), 0);
    ena_i = 1'b1;
    tick();

    // Switch to select 2, then 3 (needs 9 strobes).
    sel_req_i = 2'd2;
    q_flush.push_back(2);
    q_valid.push_back(2'd2);
    ticks(8);
    pulse_filt(8);
    wait_valid("valid after sel2 settle");
    sel_req_i = 2'd3;
    q_flush.push_back(2);
    q_valid.push_back(2'd3);
    ticks(8);
    pulse_filt(8);
    ticks(3);
    check("valid_o low after 8 of 9", int'(valid_o), 0);
    pulse_filt(1);
    wait_valid("valid after sel3 settle");

    // Abort SETTLE of select 1 after 3 strobes; count restarts for select 0.
    sel_req_i = 2'd1;
    q_flush.push_back(2);
    ticks(8);
    pulse_filt(3);
    sel_req_i = 2'd0;
    q_flush.push_back(2);
    q_valid.push_back(2'd0);
    ticks(8);
    pulse_filt(1);
    ticks(3);
    check("valid_o low after 1 of 2", int'(valid_o), 0);
    check("busy_o high while settling", int'(busy_o), 1);
    pulse_filt(1);
    wait_valid("valid after sel0 resettle");

    // Final settling strobe coincides with the select change: change wins.
    sel_req_i = 2'd1;
    q_flush.push_back(2);
    ticks(8);
    pulse_filt(3);
    sel_req_i = 2'd2;
    q_flush.push_back(2);
    q_valid.push_back(2'd2);
    ticks(2);
    filt_strobe_i = 1'b1;
    tick();
    filt_strobe_i = 1'b0;
    ticks(8);
    pulse_filt(8);
    wait_valid("valid after collision resettle");

    // One-cycle reset mid-RUN; sync flops restart at 0 so select 0 is applied
    // briefly before the synced request 2 forces a second flush.
    ticks(2);
    rst_n = 1'b0;
    tick();
    check_zero("mid-run reset outputs");
    rst_n = 1'b1;
    q_flush.push_back(2);
    q_flush.push_back(2);
    q_valid.push_back(2'd2);
    ticks(12);
    pulse_filt(8);
    wait_valid("valid after mid-run reset");

    ticks(4);
    check("pending flush events", q_flush.size(), 0);
    check("pending valid events", q_valid.size(), 0);
    check("pending strobe events", q_strobe.size(), 0);
    check("pending drop events", q_drop.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
